// File: rtl/vc_fifo_buffer_pkg.sv
// Shared defaults and width helpers for the multi-VC input buffer.
package vc_fifo_buffer_pkg;

   localparam int TAM_FLIT   = 8;
   localparam int TAM_BUFFER = 4;
   localparam int NUM_VC_DEF = 2;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/vc_fifo_buffer_if.sv
// Push/pull request bus and per-VC status outputs of the multi-VC buffer.
interface vc_fifo_buffer_if
   import vc_fifo_buffer_pkg::*;
#(
   parameter int WIDTH  = TAM_FLIT,
   parameter int DEPTH  = TAM_BUFFER,
   parameter int NUM_VC = NUM_VC_DEF
);
   localparam int VW = idx_width(NUM_VC);
   localparam int CW = cnt_width(DEPTH);

   logic                 i_push;
   logic [VW-1:0]        i_push_vc;
   logic [WIDTH-1:0]     i_tail;
   logic                 i_pull;
   logic [VW-1:0]        i_pull_vc;
   logic [WIDTH-1:0]     o_head;
   logic [NUM_VC*CW-1:0] o_counter;
   logic [NUM_VC-1:0]    o_full;
   logic [NUM_VC-1:0]    o_empty;
   logic                 o_push_ack;
   logic                 o_pull_ack;
`ifdef FIFO_ERR_EN
   logic [NUM_VC-1:0]    o_ovf_err;
   logic [NUM_VC-1:0]    o_unf_err;

   modport slave  (input  i_push, i_push_vc, i_tail, i_pull, i_pull_vc,
                   output o_head, o_counter, o_full, o_empty, o_push_ack, o_pull_ack,
                          o_ovf_err, o_unf_err);
   modport master (output i_push, i_push_vc, i_tail, i_pull, i_pull_vc,
                   input  o_head, o_counter, o_full, o_empty, o_push_ack, o_pull_ack,
                          o_ovf_err, o_unf_err);
`else
   modport slave  (input  i_push, i_push_vc, i_tail, i_pull, i_pull_vc,
                   output o_head, o_counter, o_full, o_empty, o_push_ack, o_pull_ack);
   modport master (output i_push, i_push_vc, i_tail, i_pull, i_pull_vc,
                   input  o_head, o_counter, o_full, o_empty, o_push_ack, o_pull_ack);
`endif
endinterface

// File: rtl/vc_fifo_lane.sv
// One circular flit queue: storage, pointers, occupancy and registered full/empty flags.
module vc_fifo_lane
   import vc_fifo_buffer_pkg::*;
#(
   parameter int WIDTH = TAM_FLIT,
   parameter int DEPTH = TAM_BUFFER,
   parameter int CW    = cnt_width(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             push_en,
   input  logic             pull_en,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);
   localparam int PW = idx_width(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;

   // DEPTH need not be a power of two, so wrap explicitly
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_en) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (pull_en) begin
         rd_ptr_d = next_ptr(rd_ptr_q);
      end
      case ({push_en, pull_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == '0);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage carries no reset; a reset-time write is harmless because pointers restart
   always_ff @(posedge i_clk) begin
      mem_q <= mem_d;
   end

   assign head  = empty_q ? '0 : mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = full_q;
   assign empty = empty_q;

endmodule

// File: rtl/vc_fifo_buffer.sv
// Multi-VC router input buffer: VC decode, accept logic, head mux and count packing.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_EN is defined.
module vc_fifo_buffer
   import vc_fifo_buffer_pkg::*;
#(
   parameter int WIDTH  = TAM_FLIT,
   parameter int DEPTH  = TAM_BUFFER,
   parameter int NUM_VC = NUM_VC_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   vc_fifo_buffer_if.slave  bus
);
   localparam int VW = idx_width(NUM_VC);
   localparam int CW = cnt_width(DEPTH);

   logic [NUM_VC-1:0] push_sel, pull_sel;
   logic [NUM_VC-1:0] push_en, pull_en;
   logic [NUM_VC-1:0] full, empty;
   logic [WIDTH-1:0]  head_lane  [NUM_VC];
   logic [CW-1:0]     count_lane [NUM_VC];
   logic [WIDTH-1:0]  head;

   // Out-of-range VC indices match no lane, so such requests are never accepted
   always_comb begin
      push_sel = '0;
      pull_sel = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         push_sel[v] = (bus.i_push_vc == VW'(v));
         pull_sel[v] = (bus.i_pull_vc == VW'(v));
      end
      pull_en = pull_sel & ~empty & {NUM_VC{bus.i_pull}};
      push_en = push_sel & (~full | pull_en) & {NUM_VC{bus.i_push}};
   end

   always_comb begin
      head = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         if (pull_sel[v]) head = head_lane[v];
      end
   end

   for (genvar v = 0; v < NUM_VC; v++) begin : g_lane
      vc_fifo_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_lane (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .push_en (push_en[v]),
         .pull_en (pull_en[v]),
         .wdata   (bus.i_tail),
         .head    (head_lane[v]),
         .count   (count_lane[v]),
         .full    (full[v]),
         .empty   (empty[v])
      );
      assign bus.o_counter[v*CW +: CW] = count_lane[v];
   end

   assign bus.o_head     = head;
   assign bus.o_full     = full;
   assign bus.o_empty    = empty;
   assign bus.o_push_ack = |push_en;
   assign bus.o_pull_ack = |pull_en;

`ifdef FIFO_ERR_EN
   logic [NUM_VC-1:0] ovf_q, ovf_d;
   logic [NUM_VC-1:0] unf_q, unf_d;

   always_comb begin
      ovf_d = ovf_q | (push_sel & {NUM_VC{bus.i_push}} & ~push_en);
      unf_d = unf_q | (pull_sel & {NUM_VC{bus.i_pull}} & empty);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ovf_q <= '0;
         unf_q <= '0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign bus.o_ovf_err = ovf_q;
   assign bus.o_unf_err = unf_q;
`endif

endmodule

// File: tb/tb_vc_fifo_buffer.sv
// Scoreboard bench for vc_fifo_buffer (DEPTH=4, NUM_VC=2, WIDTH=8) against a queue-based model.
module tb_vc_fifo_buffer;
   localparam int W  = 8;
   localparam int D  = 4;
   localparam int NV = 2;
   localparam int CW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vc_fifo_buffer_if #(.WIDTH(W), .DEPTH(D), .NUM_VC(NV)) ifc ();

   vc_fifo_buffer #(.WIDTH(W), .DEPTH(D), .NUM_VC(NV)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (ifc.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] mq0[$];
   logic [W-1:0] mq1[$];
   logic [W-1:0] sb[$];
   logic [NV-1:0] m_ovf = '0;
   logic [NV-1:0] m_unf = '0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int msize(input int vc);
      return (vc == 0) ? mq0.size() : mq1.size();
   endfunction

   function automatic logic [W-1:0] mfront(input int vc);
      return (vc == 0) ? mq0[0] : mq1[0];
   endfunction

   task automatic step(input bit r, input bit push, input int pvc, input logic [W-1:0] d,
                       input bit pull, input int qvc);
      bit       e_pull, e_push;
      int       e_head, e_cnt;
      logic [NV-1:0] e_full, e_empty;
      @(negedge clk);
      rst           = r;
      ifc.i_push    = push;
      ifc.i_push_vc = pvc[0];
      ifc.i_tail    = d;
      ifc.i_pull    = pull;
      ifc.i_pull_vc = qvc[0];
      #1;
      e_pull = pull && (qvc < NV) && (msize(qvc) > 0);
      e_push = push && (pvc < NV) && ((msize(pvc) < D) || (e_pull && qvc == pvc));
      if (!r) begin
         e_head = (qvc < NV && msize(qvc) > 0) ? int'(mfront(qvc)) : 0;
         e_cnt  = (msize(1) << CW) | msize(0);
         for (int v = 0; v < NV; v++) begin
            e_full[v]  = (msize(v) == D);
            e_empty[v] = (msize(v) == 0);
         end
         chk("pull_ack", int'(ifc.o_pull_ack), int'(e_pull));
         chk("push_ack", int'(ifc.o_push_ack), int'(e_push));
         chk("head",     int'(ifc.o_head), e_head);
         chk("counter",  int'(ifc.o_counter), e_cnt);
         chk("full",     int'(ifc.o_full), int'(e_full));
         chk("empty",    int'(ifc.o_empty), int'(e_empty));
`ifdef FIFO_ERR_EN
         chk("ovf_err",  int'(ifc.o_ovf_err), int'(m_ovf));
         chk("unf_err",  int'(ifc.o_unf_err), int'(m_unf));
`endif
         if (e_pull) sb.push_back(mfront(qvc));
      end
      @(posedge clk);
      if (r) begin
         mq0.delete();
         mq1.delete();
         m_ovf = '0;
         m_unf = '0;
      end else begin
         if (e_pull) begin
            if (qvc == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
         end
         if (e_push) begin
            if (pvc == 0) mq0.push_back(d); else mq1.push_back(d);
         end
         if (push && pvc < NV && !e_push) m_ovf[pvc] = 1'b1;
         if (pull && qvc < NV && !e_pull) m_unf[qvc] = 1'b1;
      end
   endtask

   // Monitor: every accepted pull must present the flit the model predicted
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (ifc.o_pull_ack === 1'b1 && rst === 1'b0) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_underrun actual=0x%0h expected=none at %0t", ifc.o_head, $time);
            end else begin
               e = sb.pop_front();
               chk("sb_head", int'(ifc.o_head), int'(e));
            end
         end
      end
   end

   initial begin
      ifc.i_push = 1'b0; ifc.i_push_vc = '0; ifc.i_tail = '0;
      ifc.i_pull = 1'b0; ifc.i_pull_vc = '0;

      // reset with a push active
      step(1, 1, 0, 8'h99, 0, 0);
      step(1, 1, 1, 8'h98, 0, 0);
      step(0, 0, 0, 8'h00, 0, 0);
      chk("rst_empty", int'(ifc.o_empty), 3);
      chk("rst_count", int'(ifc.o_counter), 0);

      // fill VC1, overflow attempt, drain
      for (int i = 0; i < 4; i++) step(0, 1, 1, 8'(8'h11 + i), 0, 0);
      step(0, 1, 1, 8'h15, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00, 1, 1);

      // wrap on VC0 with one flit in flight
      for (int i = 0; i < 10; i++) begin
         step(0, 1, 0, 8'(8'h40 + i), 0, 0);
         step(0, 0, 0, 8'h00, 1, 0);
      end

      // full pass-through on VC0
      for (int i = 0; i < 4; i++) step(0, 1, 0, 8'(8'hA0 + i), 0, 0);
      step(0, 1, 0, 8'hAA, 1, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00, 1, 0);

      // push into empty VC with same-cycle pull is rejected for the pull
      step(0, 1, 1, 8'h77, 1, 1);
      step(0, 0, 0, 8'h00, 1, 1);

      // cross-VC independence
      for (int i = 0; i < 3; i++) step(0, 1, 0, 8'(8'hC0 + i), 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 1, 8'(8'hD0 + i), 1, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 1, 1);

      // error flags (only observable with FIFO_ERR_EN), then reset clears them
      step(0, 0, 0, 8'h00, 1, 1);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'hE0 + i), 0, 0);
      step(0, 0, 0, 8'h00, 0, 0);
      step(1, 0, 0, 8'h00, 0, 0);
      step(0, 0, 0, 8'h00, 0, 0);

      // randomized traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         bit r;
         r = ($urandom_range(0, 99) == 0);
         step(r, ($urandom_range(0, 9) < 6), int'($urandom_range(0, 1)), 8'($urandom),
              r ? 1'b0 : ($urandom_range(0, 9) < 5), int'($urandom_range(0, 1)));
      end

      step(0, 0, 0, 8'h00, 0, 0);
      @(negedge clk);
      #3;
      chk("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
